// File: rtl/motoro3_ramp_ctrl.sv
// motoro3_ramp_ctrl: run/speed sequencer for the 3-phase motor datapath.
// Soft start/stop ramps, target editing and reversal through a dead dwell.

module motoro3_ramp_ctrl #(
  parameter int TICK_DIV    = 10000,
  parameter int SPD_W       = 16,
  parameter int SPD_MIN     = 10,
  parameter int SPD_MAX     = 3000,
  parameter int SPD_DEF     = 600,
  parameter int KEY_STEP    = 50,
  parameter int RAMP_STEP   = 1,
  parameter int DWELL_TICKS = 200
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             m3start,
  input  logic             m3forceStop,
  input  logic             m3invRotate,
  input  logic             m3freqINC,
  input  logic             m3freqDEC,
  output logic             runEn,
  output logic             dirPos,
  output logic [SPD_W-1:0] speedNow,
  output logic [SPD_W-1:0] speedTgt,
  output logic             atSpeed,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEL  = 3'd1,
    S_CRUISE = 3'd2,
    S_DECEL  = 3'd3,
    S_DWELL  = 3'd4
  } state_e;

  localparam int TCW = $clog2(TICK_DIV);
  localparam int DWW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam int SPX = SPD_W + 1;

  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
  localparam logic [DWW-1:0] DW_LAST   = DWW'(DWELL_TICKS - 1);

  localparam logic [SPD_W-1:0] MIN_S = SPD_W'(SPD_MIN);
  localparam logic [SPD_W-1:0] MAX_S = SPD_W'(SPD_MAX);
  localparam logic [SPD_W-1:0] DEF_S = SPD_W'(SPD_DEF);

  localparam logic [SPX-1:0] MIN_X  = SPX'(SPD_MIN);
  localparam logic [SPX-1:0] MAX_X  = SPX'(SPD_MAX);
  localparam logic [SPX-1:0] KEY_X  = SPX'(KEY_STEP);
  localparam logic [SPX-1:0] RAMP_X = SPX'(RAMP_STEP);

  localparam int E_START = 0;
  localparam int E_INV   = 1;
  localparam int E_INC   = 2;
  localparam int E_DEC   = 3;

  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] prev_q, prev_d;
  logic [3:0] evt_q, evt_d;
  logic       fs1_q, fs1_d;
  logic       fs2_q, fs2_d;

  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic           tick;

  state_e           state_q, state_d;
  logic             run_q, run_d;
  logic             dir_q, dir_d;
  logic             rev_q, rev_d;
  logic             at_q, at_d;
  logic [SPD_W-1:0] spd_q, spd_d;
  logic [SPD_W-1:0] tgt_q, tgt_d;
  logic [DWW-1:0]   dw_q, dw_d;

  logic [SPX-1:0]   tgt_x, spd_x;
  logic [SPX-1:0]   inc_x, dec_x;
  logic [SPX-1:0]   up_x, dn_x;
  logic [SPD_W-1:0] ramp_s, decel_s;

  logic ev_start, ev_inv, ev_inc, ev_dec, frc;

  // Two-flop synchronizers, then a registered rising-edge pulse.
  always_comb begin
    sync1_d = {m3freqDEC, m3freqINC, m3invRotate, m3start};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    evt_d   = sync2_q & ~prev_q;
    fs1_d   = m3forceStop;
    fs2_d   = fs1_q;
  end

  assign ev_start = evt_q[E_START];
  assign ev_inv   = evt_q[E_INV];
  assign ev_inc   = evt_q[E_INC];
  assign ev_dec   = evt_q[E_DEC];
  assign frc      = fs2_q;

  // Free-running ramp tick divider, never cleared by state changes.
  always_comb begin
    tick   = (tcnt_q == TICK_LAST);
    tcnt_d = tick ? '0 : tcnt_q + TCW'(1);
  end

  // Saturating target edits and ramp step candidates, one bit wider.
  always_comb begin
    tgt_x = {1'b0, tgt_q};
    spd_x = {1'b0, spd_q};
    inc_x = tgt_x + KEY_X;
    dec_x = tgt_x - KEY_X;
    up_x  = spd_x + RAMP_X;
    dn_x  = spd_x - RAMP_X;

    tgt_d = tgt_q;
    if (ev_inc && !ev_dec) begin
      tgt_d = (inc_x > MAX_X) ? MAX_S : inc_x[SPD_W-1:0];
    end else if (ev_dec && !ev_inc) begin
      tgt_d = (dec_x[SPD_W] || dec_x < MIN_X) ? MIN_S : dec_x[SPD_W-1:0];
    end

    ramp_s = tgt_q;
    if (spd_q < tgt_q) begin
      ramp_s = (up_x > tgt_x) ? tgt_q : up_x[SPD_W-1:0];
    end else if (spd_q > tgt_q) begin
      ramp_s = (dn_x[SPD_W] || dn_x < tgt_x) ? tgt_q : dn_x[SPD_W-1:0];
    end

    decel_s = (dn_x[SPD_W] || dn_x < MIN_X) ? MIN_S : dn_x[SPD_W-1:0];
  end

  // Sequencer next state: force stop, then start/reverse, then ticks.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    dir_d   = dir_q;
    rev_d   = rev_q;
    spd_d   = spd_q;
    dw_d    = dw_q;

    if (frc) begin
      state_d = S_IDLE;
      run_d   = 1'b0;
      spd_d   = '0;
      rev_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ev_start) begin
            state_d = S_ACCEL;
            run_d   = 1'b1;
            spd_d   = MIN_S;
          end else if (ev_inv) begin
            dir_d = ~dir_q;
          end
        end
        S_ACCEL: begin
          // After a reversal, runEn rises one edge after dirPos moved.
          run_d = 1'b1;
          if (ev_start) begin
            state_d = S_DECEL;
            rev_d   = 1'b0;
          end else if (ev_inv) begin
            state_d = S_DECEL;
            rev_d   = 1'b1;
          end else if (tick) begin
            spd_d = ramp_s;
            if (ramp_s == tgt_q) state_d = S_CRUISE;
          end
        end
        S_CRUISE: begin
          if (ev_start) begin
            state_d = S_DECEL;
            rev_d   = 1'b0;
          end else if (ev_inv) begin
            state_d = S_DECEL;
            rev_d   = 1'b1;
          end else if (tgt_q != spd_q) begin
            state_d = S_ACCEL;
          end
        end
        S_DECEL: begin
          if (ev_start) begin
            state_d = S_ACCEL;
            rev_d   = 1'b0;
          end else if (ev_inv) begin
            rev_d = ~rev_q;
          end else if (tick) begin
            if (spd_q == MIN_S) begin
              state_d = S_DWELL;
              run_d   = 1'b0;
              spd_d   = '0;
              dw_d    = '0;
            end else begin
              spd_d = decel_s;
            end
          end
        end
        S_DWELL: begin
          if (tick) begin
            if (dw_q == DW_LAST) begin
              dw_d = '0;
              if (rev_q) begin
                dir_d   = ~dir_q;
                rev_d   = 1'b0;
                state_d = S_ACCEL;
                spd_d   = MIN_S;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              dw_d = dw_q + DWW'(1);
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          run_d   = 1'b0;
          spd_d   = '0;
          rev_d   = 1'b0;
        end
      endcase
    end

    at_d = (state_d == S_CRUISE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      evt_q   <= '0;
      fs1_q   <= 1'b0;
      fs2_q   <= 1'b0;
      tcnt_q  <= '0;
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      dir_q   <= 1'b1;
      rev_q   <= 1'b0;
      at_q    <= 1'b0;
      spd_q   <= '0;
      tgt_q   <= DEF_S;
      dw_q    <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      evt_q   <= evt_d;
      fs1_q   <= fs1_d;
      fs2_q   <= fs2_d;
      tcnt_q  <= tcnt_d;
      state_q <= state_d;
      run_q   <= run_d;
      dir_q   <= dir_d;
      rev_q   <= rev_d;
      at_q    <= at_d;
      spd_q   <= spd_d;
      tgt_q   <= tgt_d;
      dw_q    <= dw_d;
    end
  end

  assign runEn    = run_q;
  assign dirPos   = dir_q;
  assign speedNow = spd_q;
  assign speedTgt = tgt_q;
  assign atSpeed  = at_q;
  assign state    = state_q;

endmodule

// File: tb/tb_motoro3_ramp_ctrl.sv
// tb_motoro3_ramp_ctrl: vector table, directed sequences and random
// stimulus against a cycle-level behavioural model of the sequencer.
`timescale 1ns/1ps

module tb_motoro3_ramp_ctrl;

  localparam int TD  = 4;
  localparam int MIN = 10;
  localparam int MAX = 40;
  localparam int DEF = 20;
  localparam int KS  = 5;
  localparam int RS  = 3;
  localparam int DT  = 2;

  localparam logic [4:0] ST = 5'b00001;
  localparam logic [4:0] FS = 5'b00010;
  localparam logic [4:0] IV = 5'b00100;
  localparam logic [4:0] IN = 5'b01000;
  localparam logic [4:0] DE = 5'b10000;

  logic        clk  = 1'b0;
  logic        nRst = 1'b1;
  logic [4:0]  in_v = '0;
  logic        runEn, dirPos, atSpeed;
  logic [15:0] speedNow, speedTgt;
  logic [2:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  motoro3_ramp_ctrl #(
    .TICK_DIV(TD), .SPD_W(16), .SPD_MIN(MIN), .SPD_MAX(MAX),
    .SPD_DEF(DEF), .KEY_STEP(KS), .RAMP_STEP(RS), .DWELL_TICKS(DT)
  ) dut (
    .clk(clk), .nRst(nRst),
    .m3start(in_v[0]), .m3forceStop(in_v[1]), .m3invRotate(in_v[2]),
    .m3freqINC(in_v[3]), .m3freqDEC(in_v[4]),
    .runEn(runEn), .dirPos(dirPos), .speedNow(speedNow),
    .speedTgt(speedTgt), .atSpeed(atSpeed), .state(state)
  );

  always #50 clk = ~clk;

  // Behavioural model: input samples delayed by the conditioning latency,
  // tick derived from the edge count since reset release.
  int         m_st, m_spd, m_tgt, m_dw, m_e;
  bit         m_run, m_dir, m_rev, m_at;
  logic [4:0] m_h [1:4];

  function automatic void model_reset();
    m_st = 0; m_spd = 0; m_tgt = DEF; m_dw = 0; m_e = 0;
    m_run = 0; m_dir = 1; m_rev = 0; m_at = 0;
    for (int i = 1; i <= 4; i++) m_h[i] = '0;
  endfunction

  function automatic void model_step(input logic [4:0] smp);
    logic [4:0] ev;
    bit frc, tick;
    int told;
    ev   = m_h[3] & ~m_h[4];
    frc  = m_h[2][1];
    tick = (m_e % TD) == TD - 1;
    m_e++;
    m_h[4] = m_h[3]; m_h[3] = m_h[2]; m_h[2] = m_h[1]; m_h[1] = smp;
    told = m_tgt;
    if (ev[3] && !ev[4]) m_tgt = (told + KS > MAX) ? MAX : told + KS;
    else if (ev[4] && !ev[3]) m_tgt = (told - KS < MIN) ? MIN : told - KS;
    if (frc) begin
      m_st = 0; m_run = 0; m_spd = 0; m_rev = 0;
    end else begin
      case (m_st)
        0: begin
          if (ev[0]) begin m_st = 1; m_run = 1; m_spd = MIN; end
          else if (ev[2]) m_dir = !m_dir;
        end
        1, 2: begin
          if (m_st == 1) m_run = 1;
          if (ev[0]) begin m_st = 3; m_rev = 0; end
          else if (ev[2]) begin m_st = 3; m_rev = 1; end
          else if (m_st == 2) begin
            if (told != m_spd) m_st = 1;
          end else if (tick) begin
            if (m_spd < told) m_spd = (m_spd + RS > told) ? told : m_spd + RS;
            else if (m_spd > told) m_spd = (m_spd - RS < told) ? told : m_spd - RS;
            if (m_spd == told) m_st = 2;
          end
        end
        3: begin
          if (ev[0]) begin m_st = 1; m_rev = 0; end
          else if (ev[2]) m_rev = !m_rev;
          else if (tick) begin
            if (m_spd == MIN) begin
              m_st = 4; m_run = 0; m_spd = 0; m_dw = 0;
            end else begin
              m_spd = (m_spd - RS < MIN) ? MIN : m_spd - RS;
            end
          end
        end
        4: begin
          if (tick) begin
            m_dw++;
            if (m_dw == DT) begin
              m_dw = 0;
              if (m_rev) begin
                m_dir = !m_dir; m_rev = 0; m_st = 1; m_spd = MIN;
              end else begin
                m_st = 0;
              end
            end
          end
        end
        default: m_st = 0;
      endcase
    end
    m_at = (m_st == 2);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic check_model();
    n_tests++;
    if (int'(state) != m_st || int'(speedNow) != m_spd ||
        int'(speedTgt) != m_tgt || runEn !== m_run ||
        dirPos !== m_dir || atSpeed !== m_at) begin
      n_fail++;
      $display("FAIL model t=%0t: got st=%0d spd=%0d tgt=%0d run=%0b dir=%0b at=%0b, want st=%0d spd=%0d tgt=%0d run=%0b dir=%0b at=%0b",
               $time, state, speedNow, speedTgt, runEn, dirPos, atSpeed,
               m_st, m_spd, m_tgt, m_run, m_dir, m_at);
    end
  endtask

  // One clock: drive after negedge, model on posedge, compare 1 ns later.
  task automatic cyc(input logic [4:0] v);
    in_v = v;
    @(posedge clk);
    if (!nRst) model_reset();
    else model_step(v);
    #1 check_model();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_run"}, runEn, 0);
    chk({nm, "_dir"}, dirPos, 1);
    chk({nm, "_spd"}, speedNow, 0);
    chk({nm, "_tgt"}, speedTgt, DEF);
    chk({nm, "_at"}, atSpeed, 0);
    chk({nm, "_st"}, state, 0);
  endtask

  task automatic do_reset();
    in_v = '0;
    nRst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b1;
  endtask

  typedef struct {
    logic [4:0] in;
    int hold; int wt;
    int st; int spd; int tgt; int run; int dir; int at;
  } vec_t;

  vec_t tbl [21];
  int   got [16];
  int   ng, lv, pd, pend, flips, bad, hold;
  int   want_acc [5];
  int   want_rev [10];
  logic [4:0] rv;

  initial begin
    tbl[0]  = '{ST,      2, 40,  2, 20, 20, 1, 1, 1};
    tbl[1]  = '{IN,      2, 30,  2, 25, 25, 1, 1, 1};
    tbl[2]  = '{IN,      2, 30,  2, 30, 30, 1, 1, 1};
    tbl[3]  = '{IN,      2, 30,  2, 35, 35, 1, 1, 1};
    tbl[4]  = '{DE,      2, 30,  2, 30, 30, 1, 1, 1};
    tbl[5]  = '{IN | DE, 2, 30,  2, 30, 30, 1, 1, 1};
    tbl[6]  = '{IN,      2, 30,  2, 35, 35, 1, 1, 1};
    tbl[7]  = '{IN,      2, 30,  2, 40, 40, 1, 1, 1};
    tbl[8]  = '{IN,      2, 30,  2, 40, 40, 1, 1, 1};
    tbl[9]  = '{DE,      2, 30,  2, 35, 35, 1, 1, 1};
    tbl[10] = '{ST,      2, 80,  0,  0, 35, 0, 1, 0};
    tbl[11] = '{IV,      2, 10,  0,  0, 35, 0, 0, 0};
    tbl[12] = '{IV,      2, 10,  0,  0, 35, 0, 1, 0};
    tbl[13] = '{ST,      2, 80,  2, 35, 35, 1, 1, 1};
    tbl[14] = '{IV,      2, 140, 2, 35, 35, 1, 0, 1};
    tbl[15] = '{FS,      10, 0,  0,  0, 35, 0, 0, 0};
    tbl[16] = '{FS | ST, 10, 0,  0,  0, 35, 0, 0, 0};
    tbl[17] = '{5'b0,    10, 0,  0,  0, 35, 0, 0, 0};
    tbl[18] = '{ST,      2, 80,  2, 35, 35, 1, 0, 1};
    tbl[19] = '{ST | IV, 2, 80,  0,  0, 35, 0, 0, 0};
    tbl[20] = '{ST | IV, 2, 80,  2, 35, 35, 1, 0, 1};
    want_acc = '{10, 13, 16, 19, 20};
    want_rev = '{17, 14, 11, 10, 0, 10, 13, 16, 19, 20};

    model_reset();
    #10 nRst = 1'b0;
    #1 chk_reset("rst");
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b1;

    // Event latency and soft-start ramp.
    cyc(ST); cyc(ST); cyc('0);
    chk("lat_n2", state, 0);
    cyc('0);
    chk("lat_n3", state, 1);
    chk("start_spd", speedNow, MIN);
    got[0] = speedNow; ng = 1;
    for (int i = 0; i < 80 && state != 3'd2; i++) begin
      cyc('0);
      if (speedNow != got[ng-1] && ng < 16) begin got[ng] = speedNow; ng++; end
    end
    chk("acc_n", ng, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("acc[%0d]", i), got[i], want_acc[i]);
    chk("cruise_st", state, 2);
    chk("cruise_at", atSpeed, 1);

    // Reversal: decel, dwell, flip with runEn low, then re-accelerate.
    cyc(IV); cyc(IV);
    ng = 0; lv = speedNow; pd = dirPos; pend = 0; flips = 0;
    for (int i = 0; i < 300; i++) begin
      cyc('0);
      if (speedNow != lv && ng < 16) begin got[ng] = speedNow; ng++; end
      lv = speedNow;
      if (dirPos != pd) begin
        flips++;
        chk("flip_run", runEn, 0);
        chk("flip_spd", speedNow, MIN);
        pend = 1;
      end else if (pend != 0) begin
        chk("run_after_flip", runEn, 1);
        pend = 0;
      end
      pd = dirPos;
      if (flips > 0 && state == 3'd2) break;
    end
    chk("rev_n", ng, 10);
    for (int i = 0; i < 10; i++) chk($sformatf("rev[%0d]", i), got[i], want_rev[i]);
    chk("rev_flips", flips, 1);
    chk("rev_dir", dirPos, 0);

    // Start during DECEL cancels the stop.
    cyc(ST); cyc(ST);
    for (int i = 0; i < 20 && state != 3'd3; i++) cyc('0);
    chk("to_decel", state, 3);
    cyc(ST); cyc(ST);
    bad = 0;
    for (int i = 0; i < 20 && state != 3'd1; i++) begin
      cyc('0);
      if (state == 3'd0 || state == 3'd4) bad = 1;
    end
    chk("decel_to_accel", state, 1);
    chk("no_stop", bad, 0);
    chk("cancel_run", runEn, 1);

    // Asynchronous reset mid-ACCEL.
    #20 nRst = 1'b0;
    #1 chk_reset("async");
    model_reset();
    @(negedge clk);
    nRst = 1'b1;

    // Force stop raised in ACCEL, start ignored while held.
    cyc(ST); cyc(ST); cyc('0); cyc('0);
    chk("f_accel", state, 1);
    cyc(FS); cyc(FS);
    chk("f_lat", state, 1);
    cyc(FS);
    chk("f_idle", state, 0);
    chk("f_run", runEn, 0);
    chk("f_spd", speedNow, 0);
    cyc(FS | ST); cyc(FS | ST);
    repeat (6) cyc(FS);
    chk("f_hold", state, 0);
    chk("f_hold_run", runEn, 0);
    repeat (4) cyc('0);
    chk("f_rel", state, 0);
    cyc(ST); cyc(ST); cyc('0); cyc('0);
    chk("f_restart", state, 1);

    // A held invRotate level in IDLE gives exactly one toggle.
    cyc(FS); cyc(FS); cyc(FS);
    repeat (4) cyc('0);
    chk("inv_idle", state, 0);
    repeat (6) cyc(IV);
    repeat (6) cyc('0);
    chk("held_inv_dir", dirPos, 0);
    chk("held_inv_run", runEn, 0);

    // Vector table.
    do_reset();
    for (int k = 0; k < 21; k++) begin
      repeat (tbl[k].hold) cyc(tbl[k].in);
      repeat (tbl[k].wt) cyc('0);
      n_tests++;
      if (int'(state) != tbl[k].st || int'(speedNow) != tbl[k].spd ||
          int'(speedTgt) != tbl[k].tgt || int'(runEn) != tbl[k].run ||
          int'(dirPos) != tbl[k].dir || int'(atSpeed) != tbl[k].at) begin
        n_fail++;
        $display("FAIL tbl[%0d]: got st=%0d spd=%0d tgt=%0d run=%0b dir=%0b at=%0b, want st=%0d spd=%0d tgt=%0d run=%0d dir=%0d at=%0d",
                 k, state, speedNow, speedTgt, runEn, dirPos, atSpeed,
                 tbl[k].st, tbl[k].spd, tbl[k].tgt, tbl[k].run,
                 tbl[k].dir, tbl[k].at);
      end
    end

    // Random stimulus against the model.
    do_reset();
    hold = 0;
    rv = '0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        rv = '0;
        rv[0] = ($urandom_range(5) == 0);
        rv[1] = ($urandom_range(24) == 0);
        rv[2] = ($urandom_range(7) == 0);
        rv[3] = ($urandom_range(4) == 0);
        rv[4] = ($urandom_range(4) == 0);
        hold = $urandom_range(6, 1);
      end
      cyc(rv);
      hold--;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/motoro3_ramp_ctrl.md
Name: motoro3_ramp_ctrl

Overview:
- Run/speed sequencer for the 3-phase motor datapath, in the 10 MHz motor clock domain.
- Turns the operator inputs (start, forceStop, invRotate, freqINC, freqDEC) into a ramped speed command, a run enable and a direction bit for the phase generator.
- Provides soft start, soft stop, and a safe reversal: decelerate, dead dwell, flip direction, re-accelerate.
- Its speed/direction outputs also feed the UART config/status bus.

Parameters:
- TICK_DIV, 10000: clk cycles per ramp tick (1 ms at 10 MHz); minimum 2.
- SPD_W, 16: speed word width (rounds/s).
- SPD_MIN, 10: start/stop floor speed.
- SPD_MAX, 3000: ceiling for target speed.
- SPD_DEF, 600: target speed after reset.
- KEY_STEP, 50: target change per INC/DEC event.
- RAMP_STEP, 1: speedNow change per tick while ramping.
- DWELL_TICKS, 200: dead ticks between stop and reversed restart.

Ports:
- clk, in, 1: 10 MHz motor clock.
- nRst, in, 1: reset, asynchronous, active-low.
- m3start, in, 1: async raw level; rising edge = start/stop toggle.
- m3forceStop, in, 1: async raw level; high = emergency stop, held.
- m3invRotate, in, 1: async raw level; rising edge = reverse request.
- m3freqINC, in, 1: async raw level; rising edge = target + KEY_STEP.
- m3freqDEC, in, 1: async raw level; rising edge = target - KEY_STEP.
- runEn, out, 1: phase bridge enable.
- dirPos, out, 1: 1 = positive rotation.
- speedNow, out, SPD_W: commanded instantaneous speed.
- speedTgt, out, SPD_W: target speed.
- atSpeed, out, 1: high when in CRUISE.
- state, out, 3: IDLE=0, ACCEL=1, CRUISE=2, DECEL=3, DWELL=4.

Behaviour:
- Clocking/reset: one clock, clk. nRst is asynchronous and active-low.
- Reset values: runEn=0, dirPos=1, speedNow=0, speedTgt=SPD_DEF, atSpeed=0, state=IDLE, revPend=0, tick counter=0, sync/edge flops=0.
- Input conditioning:
  - Each input passes through a 2-flop synchronizer, then an edge register.
  - Event pulse = sync & ~prev, one clk wide.
  - An input rising with setup before clk edge N produces its event at edge N+2, and the resulting state/output change at edge N+3.
  - forceStop is used as a synchronized level.
- Tick: free-running counter 0..TICK_DIV-1. tick is a 1-cycle pulse at count TICK_DIV-1, then the counter wraps to 0. The counter is not cleared by state changes.
- Target register:
  - INC: speedTgt = min(speedTgt + KEY_STEP, SPD_MAX).
  - DEC: speedTgt = max(speedTgt - KEY_STEP, SPD_MIN).
  - Arithmetic is done at SPD_W+1 bits, then saturated.
  - INC and DEC in the same cycle: no change.
  - Target edits are accepted in every state.
- Priority (highest first): forceStop > start/invRotate > INC/DEC > tick.
- forceStop high in any state:
  - Next edge: state=IDLE, runEn=0, speedNow=0, revPend=0; dirPos unchanged.
  - While high, start and invRotate events are discarded.
- IDLE:
  - start event: state=ACCEL, runEn=1, speedNow=SPD_MIN.
  - invRotate event: dirPos toggles and state stays IDLE.
- ACCEL, on each tick:
  - speedNow moves toward speedTgt by RAMP_STEP, clamped so it never overshoots. It can move down if the target was lowered.
  - When speedNow == speedTgt after the update: state=CRUISE.
- CRUISE:
  - atSpeed=1.
  - speedTgt != speedNow: next edge goes to ACCEL, atSpeed=0.
- ACCEL or CRUISE, start event: state=DECEL, revPend=0.
- ACCEL or CRUISE, invRotate event: state=DECEL, revPend=1.
- Simultaneous start and invRotate events: start wins, revPend=0.
- DECEL, on each tick:
  - speedNow = max(speedNow - RAMP_STEP, SPD_MIN).
  - A tick that finds speedNow == SPD_MIN: state=DWELL, runEn=0, speedNow=0, dwell counter=0.
- DECEL, start event: state=ACCEL (stop cancelled), revPend=0.
- DECEL, invRotate event: revPend toggles.
- DWELL:
  - Counts ticks.
  - At the DWELL_TICKS-th tick: if revPend, dirPos toggles, revPend=0, state=ACCEL, runEn=1, speedNow=SPD_MIN; else state=IDLE.
  - start and invRotate events are ignored.
- runEn and dirPos never change in the same cycle. dirPos changes only in IDLE or at DWELL exit with runEn still 0 in that cycle; runEn rises on the following edge.
- Outputs are registered, with no combinational path from inputs.
- Speed arithmetic wrap-around is impossible by construction; saturation is required at every add/sub.

Test Plan:
- Sim parameters: TICK_DIV=4, SPD_MIN=10, SPD_DEF=20, KEY_STEP=5, RAMP_STEP=3, DWELL_TICKS=2.
- Reset mid-ramp: release nRst, pulse start → ACCEL, speedNow 10,13,16,19,20 on successive ticks, then CRUISE, atSpeed=1. Assert nRst low mid-ACCEL → all outputs at reset values asynchronously.
- INC ×3 then DEC ×1 in CRUISE → speedTgt 35 then 30. INC with speedTgt=SPD_MAX → speedTgt stays SPD_MAX. INC and DEC in the same cycle → speedTgt unchanged.
- invRotate in CRUISE at 20:
  - → DECEL, speedNow 17,14,11,10.
  - → DWELL, runEn=0, speedNow=0, 2 ticks.
  - → dirPos 1→0, then next edge runEn=1, ACCEL from 10.
- start in CRUISE → DECEL to 10 → DWELL → IDLE, dirPos unchanged. start during DECEL → back to ACCEL.
- forceStop raised in ACCEL → next edge after sync latency: IDLE, runEn=0, speedNow=0. start pulses while held → no effect. Release, then start → ACCEL.
- invRotate in IDLE → dirPos toggles with runEn=0. A 1-cycle glitch between clk edges may be missed; a level held 2+ cycles yields exactly one event.
